cnt_seq_checker: RTL

- Sink-side checker for the free-running counter stream produced by the counter block (`clr` input, `dout` output).
- Samples the counter value each valid cycle and predicts the next value (+1, modulo 2^W).
- Acquires lock on the sequence, then flags and counts sequence errors.
- Sits downstream of the counter in simulation and in hardware; its status outputs feed debug logic and the bench.

---
 rtl/cnt_seq_checker.sv | 108 ++++++++++
 1 files changed

// File: rtl/cnt_seq_checker.sv
// rtl/cnt_seq_checker.sv - sequence checker for an incrementing counter stream
// Optional build macro CNT_CHK_STRICT_EN: on a locked mismatch keep the original timeline.
module cnt_seq_checker #(
    parameter int W         = 8,
    parameter int ERR_CNT_W = 8,
    parameter int SYNC_LEN  = 2,
    parameter int LOSS_LEN  = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [W-1:0]         din,
    input  logic                 din_vld,
    input  logic                 clr,
    output logic                 locked,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [W-1:0]         exp_val
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNC     = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [W-1:0]         ONE_W   = 1;
    localparam logic [ERR_CNT_W-1:0] ONE_E   = 1;
    localparam logic [3:0]           SYNC_L  = SYNC_LEN[3:0];
    localparam logic [3:0]           LOSS_L  = LOSS_LEN[3:0];

    state_t     state;
    logic [3:0] good_cnt;
    logic [3:0] miss_cnt;

    logic [W-1:0] din_nxt;
    logic [3:0]   good_nxt;
    logic [3:0]   miss_nxt;
    logic         match;

    assign din_nxt  = din + ONE_W;
    assign good_nxt = good_cnt + 4'd1;
    assign miss_nxt = miss_cnt + 4'd1;
    assign match    = (din == exp_val);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= UNLOCKED;
            locked   <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            exp_val  <= '0;
            good_cnt <= 4'd0;
            miss_cnt <= 4'd0;
        end else begin
            err <= 1'b0;
            // clr restarts the expected timeline at zero without touching lock state
            if (clr) begin
                exp_val <= '0;
            end else if (din_vld) begin
                case (state)
                    UNLOCKED: begin
                        exp_val  <= din_nxt;
                        good_cnt <= 4'd0;
                        state    <= SYNC;
                    end
                    SYNC: begin
                        exp_val <= din_nxt;
                        if (match) begin
                            good_cnt <= good_nxt;
                            if (good_nxt == SYNC_L) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= 4'd0;
                            end
                        end else begin
                            good_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            exp_val  <= din_nxt;
                            miss_cnt <= 4'd0;
                        end else begin
                            err      <= 1'b1;
                            miss_cnt <= miss_nxt;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + ONE_E;
`ifdef CNT_CHK_STRICT_EN
                            exp_val  <= exp_val + ONE_W;
`else
                            exp_val  <= din_nxt;
`endif
                            if (miss_nxt == LOSS_L) begin
                                state  <= UNLOCKED;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
